// File: rtl/sbus_master.sv
// Host-command to strobe-bus master: one SETUP/STROBE/HOLD bus cycle per command, then a held response.
// Optional macro SBUS_MASTER_RANGE_CHECK_EN rejects addresses outside the GPIO register window.
module sbus_master #(
   parameter int STROBE_CYCLES = 2,
   parameter int ADDR_W        = 16
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] saddress,
   output logic              srd,
   output logic              swr,
   output logic [31:0]       sdata_wr,
   input  logic [31:0]       sdata_rd
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              addr_ok;
   logic              bus_act;

`ifdef SBUS_MASTER_RANGE_CHECK_EN
   always_comb begin
      addr_ok = (cmd_addr == ADDR_W'('h1094)) || (cmd_addr == ADDR_W'('h1098)) ||
                (cmd_addr == ADDR_W'('h109C));
   end
`else
   always_comb begin
      addr_ok = 1'b1;
   end
`endif

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               wr_d    = cmd_wr;
               addr_d  = cmd_addr;
               wdata_d = cmd_wr ? cmd_wdata : 32'd0;
               rdata_d = 32'd0;
               cnt_d   = 4'd0;
               err_d   = !addr_ok;
               // Rejected commands skip the bus entirely and respond next cycle.
               state_d = addr_ok ? SETUP : RESP;
            end
         end
         SETUP: state_d = STROBE;
         STROBE: begin
            if (cnt_q == 4'(STROBE_CYCLES - 1)) begin
               state_d = HOLD;
               if (!wr_q) rdata_d = sdata_rd;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD: state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Bus outputs decode straight from registered state so they are zero outside a transfer.
   assign bus_act   = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
   assign saddress  = bus_act ? addr_q : '0;
   assign sdata_wr  = bus_act ? wdata_q : 32'd0;
   assign srd       = (state_q == STROBE) && !wr_q;
   assign swr       = (state_q == STROBE) && wr_q;
   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
